// File: rtl/ram_pkg.sv
// Shared types and constants for the byte-writable dual-port RAM.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  localparam int unsigned BYTE_W = 8;

  function automatic int unsigned byte_lanes(input int unsigned dw);
    return dw / BYTE_W;
  endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Post-reset zero-fill sequencer: walks every address once, one word per cycle.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int AW             = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          busy,
  output logic [AW-1:0] clr_addr,
  output logic          clr_we
);

  localparam int            DEPTH = 1 << AW;
  localparam logic [AW:0]   LAST  = (AW+1)'(DEPTH - 1);
  localparam clr_state_e    RST_STATE = CLEAR_ON_RESET ? CLEAR : READY;

  clr_state_e  state_q, state_d;
  // One spare bit keeps the terminal compare clear of wrap-around.
  logic [AW:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      READY:   state_d = READY;
      default: state_d = READY;
    endcase
  end

  assign busy     = (state_q == CLEAR);
  assign clr_addr = cnt_q[AW-1:0];

endmodule

// File: rtl/ram_dp_bw.sv
// Dual-port RAM: port A read/write with byte enables (read-first), port B read-only
// with same-address byte-merge forwarding, optional output register, zero-fill after reset.
module ram_dp_bw
  import ram_pkg::*;
#(
  parameter int DW             = 32,
  parameter int AW             = 12,
  parameter bit OUT_REG        = 1'b0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                       CLK,
  input  logic                       RESETn,
  input  logic                       ENA,
  input  logic [byte_lanes(DW)-1:0]  WEA,
  input  logic [AW-1:0]              AA,
  input  logic [DW-1:0]              DiA,
  output logic [DW-1:0]              DoA,
  input  logic                       ENB,
  input  logic [AW-1:0]              AB,
  output logic [DW-1:0]              DoB,
  output logic                       BUSY
);

  localparam int NB    = byte_lanes(DW);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  logic          busy;
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          ena_ok, enb_ok;
  logic [DW-1:0] fwd_b;
  logic [DW-1:0] doa1_d, doa1_q, dob1_d, dob1_q;

  ram_clear_ctrl #(
    .AW             (AW),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear (
    .clk      (CLK),
    .rst_n    (RESETn),
    .busy     (busy),
    .clr_addr (clr_addr),
    .clr_we   (clr_we)
  );

  assign ena_ok = ENA & ~busy;
  assign enb_ok = ENB & ~busy;

  // Single write port; the clear sequence owns it while busy.
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (ena_ok) begin
      for (int i = 0; i < NB; i++)
        if (WEA[i]) mem[AA][i*BYTE_W +: BYTE_W] <= DiA[i*BYTE_W +: BYTE_W];
    end
  end

  // Port B sees a same-cycle port A write merged per byte; port A stays read-first.
  always_comb begin
    fwd_b = mem[AB];
    if (ena_ok && (AA == AB)) begin
      for (int i = 0; i < NB; i++)
        if (WEA[i]) fwd_b[i*BYTE_W +: BYTE_W] = DiA[i*BYTE_W +: BYTE_W];
    end
    doa1_d = ena_ok ? mem[AA] : '0;
    dob1_d = enb_ok ? fwd_b   : '0;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      doa1_q <= '0;
      dob1_q <= '0;
    end else begin
      doa1_q <= doa1_d;
      dob1_q <= dob1_d;
    end
  end

  generate
    if (OUT_REG) begin : g_oreg
      logic [DW-1:0] doa2_q, dob2_q;
      always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
          doa2_q <= '0;
          dob2_q <= '0;
        end else begin
          doa2_q <= doa1_q;
          dob2_q <= dob1_q;
        end
      end
      assign DoA = doa2_q;
      assign DoB = dob2_q;
    end else begin : g_noreg
      assign DoA = doa1_q;
      assign DoB = dob1_q;
    end
  endgenerate

  assign BUSY = busy;

endmodule

// File: tb/tb_ram_dp_bw.sv
// Directed bench: three instances (plain, output-registered, no-clear) share one stimulus.
module tb_ram_dp_bw;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RESETn;
  logic          ENA, ENB;
  logic [3:0]    WEA;
  logic [AW-1:0] AA, AB;
  logic [DW-1:0] DiA;
  logic [DW-1:0] doa0, dob0, doa1, dob1, doa2, dob2;
  logic          busy0, busy1, busy2;

  int n_chk = 0;
  int n_err = 0;
  int n;

  always #5 CLK = ~CLK;

  ram_dp_bw #(.DW(DW), .AW(AW), .OUT_REG(1'b0), .CLEAR_ON_RESET(1'b1)) u_dut0 (
    .CLK(CLK), .RESETn(RESETn), .ENA(ENA), .WEA(WEA), .AA(AA), .DiA(DiA), .DoA(doa0),
    .ENB(ENB), .AB(AB), .DoB(dob0), .BUSY(busy0));

  ram_dp_bw #(.DW(DW), .AW(AW), .OUT_REG(1'b1), .CLEAR_ON_RESET(1'b1)) u_dut1 (
    .CLK(CLK), .RESETn(RESETn), .ENA(ENA), .WEA(WEA), .AA(AA), .DiA(DiA), .DoA(doa1),
    .ENB(ENB), .AB(AB), .DoB(dob1), .BUSY(busy1));

  ram_dp_bw #(.DW(DW), .AW(AW), .OUT_REG(1'b0), .CLEAR_ON_RESET(1'b0)) u_dut2 (
    .CLK(CLK), .RESETn(RESETn), .ENA(ENA), .WEA(WEA), .AA(AA), .DiA(DiA), .DoA(doa2),
    .ENB(ENB), .AB(AB), .DoB(dob2), .BUSY(busy2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ENA = 1'b0; ENB = 1'b0; WEA = '0; AA = '0; AB = '0; DiA = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [3:0] we, input logic [31:0] d);
    idle();
    ENA = 1'b1; WEA = we; AA = a; DiA = d;
    tick();
  endtask

  // Counts edges until BUSY on the plain instance drops, bounded.
  task automatic wait_clear(output int cyc);
    cyc = 0;
    while (busy0 && cyc < 40) begin
      tick();
      cyc++;
      if (cyc == 8) begin
        chk("mid_clear_doa", doa0, 32'h0);
        chk("mid_clear_dob", dob0, 32'h0);
      end
    end
  endtask

  initial begin
    RESETn = 1'b0;
    idle();
    repeat (2) tick();
    chk("rst_busy0", busy0, 1);
    chk("rst_busy1", busy1, 1);
    chk("rst_busy2", busy2, 0);
    chk("rst_doa0", doa0, 0);
    chk("rst_dob0", dob0, 0);
    chk("rst_dob1", dob1, 0);

    // Writes attempted during the clear must not land.
    ENA = 1'b1; WEA = 4'hF; AA = 4'd9; DiA = 32'hFFFF_FFFF; ENB = 1'b1; AB = 4'd9;
    RESETn = 1'b1;
    wait_clear(n);
    chk("busy_cycles", n, 16);
    chk("busy1_done", busy1, 0);
    chk("busy2_idle", busy2, 0);

    for (int a = 0; a < 16; a++) begin
      idle();
      ENA = 1'b1; AA = AW'(a); ENB = 1'b1; AB = AW'(15 - a);
      tick();
      chk($sformatf("zero_a%0d", a), doa0, 32'h0);
      chk($sformatf("zero_b%0d", 15 - a), dob0, 32'h0);
    end

    // Byte-lane partial write; second write also checks read-first on port A.
    wr(4'd5, 4'hF, 32'hDEAD_BEEF);
    wr(4'd5, 4'b0010, 32'h0000_1200);
    chk("read_first_a", doa0, 32'hDEAD_BEEF);
    idle(); ENA = 1'b1; AA = 4'd5; tick();
    chk("bytewr_a", doa0, 32'hDEAD_12EF);
    chk("bytewr_noclr", doa2, 32'hDEAD_12EF);
    idle(); tick();
    chk("dis_a", doa0, 32'h0);

    // Same-address collision: B merges per byte, A returns old.
    wr(4'd7, 4'hF, 32'h1122_3344);
    idle();
    ENA = 1'b1; AA = 4'd7; WEA = 4'b0101; DiA = 32'hAABB_CCDD; ENB = 1'b1; AB = 4'd7;
    tick();
    chk("coll_b", dob0, 32'h11BB_33DD);
    chk("coll_a", doa0, 32'h1122_3344);
    idle(); ENB = 1'b1; AB = 4'd7; tick();
    chk("coll_b_oreg", dob1, 32'h11BB_33DD);
    chk("coll_mem", dob0, 32'h11BB_33DD);

    // Output-register latency: 2 cycles from the enable edge.
    wr(4'd3, 4'hF, 32'hCAFE_F00D);
    idle(); ENB = 1'b1; AB = 4'd3; tick();
    chk("oreg_e1", dob1, 32'h0);
    chk("plain_e1", dob0, 32'hCAFE_F00D);
    idle(); tick();
    chk("oreg_e2", dob1, 32'hCAFE_F00D);
    chk("plain_dis", dob0, 32'h0);
    tick();
    chk("oreg_dis", dob1, 32'h0);

    // Reset mid-clear at count 7; the full clear must rerun.
    wr(4'd12, 4'hF, 32'h1234_5678);
    idle();
    RESETn = 1'b0; #2;
    chk("rst2_busy", busy0, 1);
    RESETn = 1'b1;
    repeat (7) tick();
    chk("pre_abort_busy", busy0, 1);
    RESETn = 1'b0; #2;
    chk("abort_busy", busy0, 1);
    chk("abort_dob1", dob1, 0);
    RESETn = 1'b1;
    wait_clear(n);
    chk("busy_cycles_restart", n, 16);
    idle(); ENA = 1'b1; AA = 4'd12; ENB = 1'b1; AB = 4'd5; tick();
    chk("restart_clr_12", doa0, 32'h0);
    chk("restart_clr_5", dob0, 32'h0);
    chk("noclr_keeps_12", doa2, 32'h1234_5678);
    chk("noclr_busy", busy2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
